// File: rtl/ram_bist_if.sv
// RAM command/response bundle between the March C- BIST engine (master)
// and the single-port synchronous RAM (slave).
interface ram_bist_if #(
    parameter int AW = 2,
    parameter int DW = 3
);
    logic [AW-1:0] A;
    logic [DW-1:0] D;
    logic          EN;
    logic          WR;
    logic [DW-1:0] Q;

    modport master (output A, D, EN, WR, input Q);
    modport slave  (input A, D, EN, WR, output Q);
endinterface

// File: rtl/ram_bist.sv
// March C- BIST engine driving a single-port synchronous RAM with registered Q.
// Optional macro RAM_BIST_ERRCNT_EN: adds ERR_CNT and runs to completion on mismatch.
module ram_bist #(
    parameter int AW = 2,
    parameter int DW = 3
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          START,
    output logic          BUSY,
    output logic          DONE,
    output logic          FAIL,
    output logic [AW-1:0] FAIL_ADDR,
    output logic [2:0]    FAIL_ELEM,
`ifdef RAM_BIST_ERRCNT_EN
    output logic [7:0]    ERR_CNT,
`endif
    ram_bist_if.master    ram
);
    typedef enum logic [2:0] {IDLE, RUN_W, RUN_R, RUN_C, FIN} state_t;

    localparam logic [AW-1:0] AMAX = '1;

    state_t        state_q;
    logic [2:0]    elem_q;
    logic [AW-1:0] addr_q;
    logic          busy_q, done_q, fail_q;
    logic [AW-1:0] faddr_q;
    logic [2:0]    felem_q;
    logic [AW-1:0] a_q;
    logic [DW-1:0] d_q;
    logic          en_q, wr_q;

    // Elements 3 and 4 walk the address space downwards.
    function automatic logic is_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic logic [DW-1:0] wpat(input logic [2:0] e);
        return {DW{(e == 3'd1) || (e == 3'd3)}};
    endfunction

    function automatic logic [DW-1:0] rpat(input logic [2:0] e);
        return {DW{(e == 3'd2) || (e == 3'd4)}};
    endfunction

    logic [2:0]    elem_inc;
    logic [AW-1:0] nxt_addr;
    logic [AW-1:0] first_nxt;
    logic          last_addr;
    logic          mism;
    logic          abort;

    assign elem_inc  = elem_q + 3'd1;
    assign nxt_addr  = is_down(elem_q) ? addr_q - 1'b1 : addr_q + 1'b1;
    assign first_nxt = is_down(elem_inc) ? AMAX : '0;
    assign last_addr = (addr_q == (is_down(elem_q) ? '0 : AMAX));
    assign mism      = (ram.Q != rpat(elem_q));

`ifdef RAM_BIST_ERRCNT_EN
    logic [7:0] errcnt_q;
    assign ERR_CNT = errcnt_q;
    assign abort   = 1'b0;
`else
    assign abort   = mism;
`endif

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            elem_q  <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            faddr_q <= '0;
            felem_q <= '0;
            a_q     <= '0;
            d_q     <= '0;
            en_q    <= 1'b0;
            wr_q    <= 1'b0;
`ifdef RAM_BIST_ERRCNT_EN
            errcnt_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (START) begin
                    state_q <= RUN_W;
                    elem_q  <= '0;
                    addr_q  <= '0;
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                    fail_q  <= 1'b0;
                    faddr_q <= '0;
                    felem_q <= '0;
                    a_q     <= '0;
                    d_q     <= '0;
                    en_q    <= 1'b1;
                    wr_q    <= 1'b1;
`ifdef RAM_BIST_ERRCNT_EN
                    errcnt_q <= '0;
`endif
                end
                RUN_W: begin
                    if (elem_q == 3'd0 && !last_addr) begin
                        addr_q <= nxt_addr;
                        a_q    <= nxt_addr;
                        d_q    <= wpat(elem_q);
                    end else begin
                        // A write closes an address; next is a read, possibly of the next element.
                        state_q <= RUN_R;
                        wr_q    <= 1'b0;
                        if (last_addr) begin
                            elem_q <= elem_inc;
                            addr_q <= first_nxt;
                            a_q    <= first_nxt;
                        end else begin
                            addr_q <= nxt_addr;
                            a_q    <= nxt_addr;
                        end
                    end
                end
                RUN_R: begin
                    state_q <= RUN_C;
                    en_q    <= 1'b0;
                end
                RUN_C: begin
                    if (mism && !fail_q) begin
                        fail_q  <= 1'b1;
                        faddr_q <= addr_q;
                        felem_q <= elem_q;
                    end
`ifdef RAM_BIST_ERRCNT_EN
                    if (mism && errcnt_q != 8'hFF) errcnt_q <= errcnt_q + 8'd1;
`endif
                    if (abort || (elem_q == 3'd5 && last_addr)) begin
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (elem_q == 3'd5) begin
                        state_q <= RUN_R;
                        addr_q  <= nxt_addr;
                        a_q     <= nxt_addr;
                        en_q    <= 1'b1;
                        wr_q    <= 1'b0;
                    end else begin
                        state_q <= RUN_W;
                        a_q     <= addr_q;
                        d_q     <= wpat(elem_q);
                        en_q    <= 1'b1;
                        wr_q    <= 1'b1;
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign FAIL      = fail_q;
    assign FAIL_ADDR = faddr_q;
    assign FAIL_ELEM = felem_q;
    assign ram.A     = a_q;
    assign ram.D     = d_q;
    assign ram.EN    = en_q;
    assign ram.WR    = wr_q;
endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: fault-injecting RAM model, March C- reference model feeding
// an expected-command scoreboard, and end-of-run status checks.
module tb_ram_bist;
    localparam int AW = 2;
    localparam int DW = 3;
    localparam int N  = 1 << AW;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          START = 1'b0;
    logic          BUSY, DONE, FAIL;
    logic [AW-1:0] FAIL_ADDR;
    logic [2:0]    FAIL_ELEM;
`ifdef RAM_BIST_ERRCNT_EN
    logic [7:0]    ERR_CNT;
`endif

    ram_bist_if #(.AW(AW), .DW(DW)) ram ();

    ram_bist #(.AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RSTN(RSTN), .START(START), .BUSY(BUSY), .DONE(DONE),
        .FAIL(FAIL), .FAIL_ADDR(FAIL_ADDR), .FAIL_ELEM(FAIL_ELEM),
`ifdef RAM_BIST_ERRCNT_EN
        .ERR_CNT(ERR_CNT),
`endif
        .ram(ram)
    );

    always #5 CLK = ~CLK;

    // RAM with one optional stuck-at bit
    logic [DW-1:0] mem [N];
    logic flt_on = 1'b0;
    int   flt_a = 0, flt_b = 0;
    logic flt_v = 1'b0;

    function automatic logic [DW-1:0] stuck(input int a, input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = d;
        if (flt_on && a == flt_a) r[flt_b] = flt_v;
        return r;
    endfunction

    always @(posedge CLK) if (ram.EN) begin
        if (ram.WR) mem[ram.A] <= stuck(int'(ram.A), ram.D);
        else        ram.Q <= mem[ram.A];
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          wr;
    } cmd_t;

    cmd_t exp_q[$];
    cmd_t mc;
    int n_chk = 0, n_err = 0;
    int exp_cyc, exp_fail, exp_fa, exp_fe, exp_ec;
    int busy_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // March C- reference: expected command stream and final status
    task automatic model();
        logic [DW-1:0] m [N];
        int cyc = 0, ec = 0;
        bit stop = 0;
        exp_fail = 0; exp_fa = 0; exp_fe = 0;
        for (int e = 0; e < 6 && !stop; e++) begin
            for (int k = 0; k < N && !stop; k++) begin
                int a;
                logic [DW-1:0] want, w;
                a    = (e == 3 || e == 4) ? N - 1 - k : k;
                want = (e == 2 || e == 4) ? '1 : '0;
                w    = (e == 1 || e == 3) ? '1 : '0;
                if (e > 0) begin
                    exp_q.push_back('{a: a[AW-1:0], d: '0, wr: 1'b0});
                    cyc += 2;
                    if (m[a] != want) begin
                        ec++;
                        if (exp_fail == 0) begin exp_fail = 1; exp_fa = a; exp_fe = e; end
`ifndef RAM_BIST_ERRCNT_EN
                        stop = 1;
`endif
                    end
                end
                if (e < 5 && !stop) begin
                    exp_q.push_back('{a: a[AW-1:0], d: w, wr: 1'b1});
                    m[a] = stuck(a, w);
                    cyc++;
                end
            end
        end
        exp_cyc = cyc;
        exp_ec  = (ec > 255) ? 255 : ec;
    endtask

    // Monitor: every issued RAM command must be the next expected one
    always @(negedge CLK) if (RSTN) begin
        if (BUSY) busy_cnt++;
        if (ram.EN) begin
            if (exp_q.size() == 0) chk("cmd_unexpected", 1, 0);
            else begin
                mc = exp_q.pop_front();
                chk("cmd_A", int'(ram.A), int'(mc.a));
                chk("cmd_WR", int'(ram.WR), int'(mc.wr));
                if (mc.wr) chk("cmd_D", int'(ram.D), int'(mc.d));
            end
        end
    end

    task automatic run_test(input string nm, input bit f_on, input int fa, input int fb,
                            input bit fv, input int restart_at);
        flt_on = f_on; flt_a = fa; flt_b = fb; flt_v = fv;
        exp_q.delete();
        model();
        @(negedge CLK);
        busy_cnt = 0;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        chk({nm, "_busy_on"}, int'(BUSY), 1);
        chk({nm, "_done_clr"}, int'(DONE), 0);
        chk({nm, "_fail_clr"}, int'(FAIL), 0);
        for (int i = 0; i < 400 && !DONE; i++) begin
            @(negedge CLK);
            START = (restart_at > 0 && i == restart_at);
        end
        START = 1'b0;
        if (!DONE) chk({nm, "_timeout"}, 0, 1);
        chk({nm, "_cycles"}, busy_cnt, exp_cyc);
        chk({nm, "_busy_off"}, int'(BUSY), 0);
        chk({nm, "_fail"}, int'(FAIL), exp_fail);
        chk({nm, "_fail_addr"}, int'(FAIL_ADDR), exp_fa);
        chk({nm, "_fail_elem"}, int'(FAIL_ELEM), exp_fe);
`ifdef RAM_BIST_ERRCNT_EN
        chk({nm, "_err_cnt"}, int'(ERR_CNT), exp_ec);
`endif
        chk({nm, "_cmds_left"}, exp_q.size(), 0);
        repeat (3) @(negedge CLK);
        chk({nm, "_en_after"}, int'(ram.EN), 0);
        chk({nm, "_done_hold"}, int'(DONE), 1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_BUSY"}, int'(BUSY), 0);
        chk({nm, "_DONE"}, int'(DONE), 0);
        chk({nm, "_FAIL"}, int'(FAIL), 0);
        chk({nm, "_FAIL_ADDR"}, int'(FAIL_ADDR), 0);
        chk({nm, "_FAIL_ELEM"}, int'(FAIL_ELEM), 0);
        chk({nm, "_A"}, int'(ram.A), 0);
        chk({nm, "_D"}, int'(ram.D), 0);
        chk({nm, "_EN"}, int'(ram.EN), 0);
        chk({nm, "_WR"}, int'(ram.WR), 0);
    endtask

    initial begin
        #12;
        chk_zero("reset");
        @(negedge CLK);
        RSTN = 1'b1;

        run_test("clean", 0, 0, 0, 0, -1);
        run_test("sa0_a2b0", 1, 2, 0, 0, -1);
        run_test("restart10", 0, 0, 0, 0, 10);

        // Reset in the middle of a run
        flt_on = 1'b0;
        exp_q.delete();
        model();
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (19) @(negedge CLK);
        chk("midrst_busy_before", int'(BUSY), 1);
        RSTN = 1'b0;
        #1;
        chk_zero("midrst");
        exp_q.delete();
        @(negedge CLK);
        RSTN = 1'b1;
        run_test("after_rst", 0, 0, 0, 0, -1);

        run_test("b2b_fail", 1, 1, 2, 1, -1);
        run_test("b2b_clean", 0, 0, 0, 0, -1);

        for (int t = 0; t < 8; t++) begin
            run_test($sformatf("rnd%0d", t), ($urandom_range(0, 3) != 0),
                     int'($urandom_range(0, N - 1)), int'($urandom_range(0, DW - 1)),
                     1'($urandom_range(0, 1)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
